// File: rtl/sume_axi_lite_slave_regs.sv
// AXI4-Lite register block: C_NUM_RW writable registers driving hardware and C_NUM_RO
// read-only registers sampled from hardware. W_IDLE/R_IDLE wait for a request; W_RESP/R_RESP hold a response.
module sume_axi_lite_slave_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
  parameter int          C_NUM_RW           = 8,
  parameter int          C_NUM_RO           = 8
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_RW-1:0] rw_regs,
  output logic [C_NUM_RW-1:0]                  rw_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH*C_NUM_RO-1:0] ro_regs
);

  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int AW      = C_S_AXI_ADDR_WIDTH;
  localparam int NUM_TOT = C_NUM_RW + C_NUM_RO;
  localparam int RW_IW   = (C_NUM_RW > 1) ? $clog2(C_NUM_RW) : 1;
  localparam int TOT_IW  = (NUM_TOT > 1) ? $clog2(NUM_TOT) : 1;
  localparam logic [AW-1:0] BASE      = AW'(C_BASEADDR);
  localparam logic [AW-1:0] NUM_RW_A  = AW'(C_NUM_RW);
  localparam logic [AW-1:0] NUM_TOT_A = AW'(NUM_TOT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic                   awready_q, awready_next;
  logic                   bvalid_q, bvalid_next;
  logic [1:0]             bresp_q, bresp_next;
  logic [C_NUM_RW-1:0]    pulse_q, pulse_next;
  logic                   w_fire;
  logic                   arready_q, arready_next;
  logic                   rvalid_q, rvalid_next;
  logic [1:0]             rresp_q, rresp_next;
  logic [DW-1:0]          rdata_q, rdata_next;
  logic [DW*C_NUM_RW-1:0] rw_q;

  logic [AW-1:0]          w_word, r_word;
  logic                   w_ok, r_ok;
  logic [RW_IW-1:0]       w_idx;
  logic [TOT_IW-1:0]      r_idx;
  logic [DW*NUM_TOT-1:0]  all_regs;

  // Base is aligned, so the low address bits never borrow into the word index.
  assign w_word   = (S_AXI_AWADDR - BASE) >> 2;
  assign r_word   = (S_AXI_ARADDR - BASE) >> 2;
  assign w_ok     = (S_AXI_AWADDR >= BASE) && (w_word < NUM_RW_A);
  assign r_ok     = (S_AXI_ARADDR >= BASE) && (r_word < NUM_TOT_A);
  assign w_idx    = w_word[RW_IW-1:0];
  assign r_idx    = r_word[TOT_IW-1:0];
  assign all_regs = {ro_regs, rw_q};

  always_comb begin
    w_state_next = w_state;
    awready_next = 1'b0;
    bvalid_next  = bvalid_q;
    bresp_next   = bresp_q;
    pulse_next   = '0;
    w_fire       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          if (!awready_q) begin
            awready_next = 1'b1;
          end else begin
            w_fire       = 1'b1;
            bvalid_next  = 1'b1;
            bresp_next   = w_ok ? RESP_OKAY : RESP_SLVERR;
            w_state_next = W_RESP;
            if (w_ok) pulse_next[w_idx] = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_next  = 1'b0;
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    arready_next = 1'b0;
    rvalid_next  = rvalid_q;
    rresp_next   = rresp_q;
    rdata_next   = rdata_q;
    case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          if (!arready_q) begin
            arready_next = 1'b1;
          end else begin
            rvalid_next  = 1'b1;
            rresp_next   = r_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_next   = r_ok ? all_regs[DW*r_idx +: DW] : '0;
            r_state_next = R_RESP;
          end
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_next  = 1'b0;
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      pulse_q   <= '0;
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      w_state   <= w_state_next;
      awready_q <= awready_next;
      bvalid_q  <= bvalid_next;
      bresp_q   <= bresp_next;
      pulse_q   <= pulse_next;
      r_state   <= r_state_next;
      arready_q <= arready_next;
      rvalid_q  <= rvalid_next;
      rresp_q   <= rresp_next;
      rdata_q   <= rdata_next;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rw_q <= '0;
    end else if (w_fire && w_ok) begin
      for (int b = 0; b < DW/8; b++) begin
        if (S_AXI_WSTRB[b]) rw_q[DW*w_idx + 8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign rw_regs       = rw_q;
  assign rw_wr_pulse   = pulse_q;

endmodule

// File: tb/tb_sume_axi_lite_slave_regs.sv
// Scoreboard bench for sume_axi_lite_slave_regs: drivers push expected responses from a
// register-map model; a negedge monitor pops and compares on each B/R response.
module tb_sume_axi_lite_slave_regs;
  localparam int          NUM_RW = 8;
  localparam int          NUM_RO = 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic clk, aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [32*NUM_RW-1:0] rw_regs;
  logic [NUM_RW-1:0]    rw_wr_pulse;
  logic [32*NUM_RO-1:0] ro_regs;

  sume_axi_lite_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .C_BASEADDR(BASE),
    .C_NUM_RW(NUM_RW), .C_NUM_RO(NUM_RO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .rw_regs(rw_regs), .rw_wr_pulse(rw_wr_pulse), .ro_regs(ro_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] resp; logic [NUM_RW-1:0] pulse; logic [32*NUM_RW-1:0] regs; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t b_cur;
  bit     b_have;
  logic   bvalid_prev;
  logic [31:0] mrw [NUM_RW];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint word_of(input logic [31:0] addr);
    if (addr < BASE) return -1;
    return longint'(addr - BASE) / 4;
  endfunction

  function automatic logic [32*NUM_RW-1:0] model_flat();
    logic [32*NUM_RW-1:0] f;
    for (int i = 0; i < NUM_RW; i++) f[32*i +: 32] = mrw[i];
    return f;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_exp_t e;
    longint w;
    bit ok;
    w = word_of(addr);
    if (w >= 0 && w < NUM_RW) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mrw[w][8*b +: 8] = data[8*b +: 8];
      e.resp  = 2'b00;
      e.pulse = NUM_RW'(1) << w;
    end else begin
      e.resp  = 2'b10;
      e.pulse = '0;
    end
    e.regs = model_flat();
    bq.push_back(e);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    check("aw_w_accept", 256'(ok), 256'(1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr);
    r_exp_t e;
    longint w;
    bit ok;
    w = word_of(addr);
    if (w >= 0 && w < NUM_RW) begin
      e.data = mrw[w]; e.resp = 2'b00;
    end else if (w >= NUM_RW && w < NUM_RW + NUM_RO) begin
      e.data = ro_regs[32*(w-NUM_RW) +: 32]; e.resp = 2'b00;
    end else begin
      e.data = 32'h0; e.resp = 2'b10;
    end
    rq.push_back(e);
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    check("ar_accept", 256'(ok), 256'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bq.size() == 0 && rq.size() == 0 && !b_have && !bvalid && !rvalid) begin ok = 1'b1; break; end
    end
    check("drain", 256'(ok), 256'(1));
  endtask

  // Monitor: compares every response the DUT presents against the queued expectation.
  initial begin
    b_have = 1'b0;
    bvalid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        b_have = 1'b0;
        bvalid_prev = 1'b0;
      end else begin
        logic rising;
        rising = bvalid && !bvalid_prev;
        if (rising) begin
          if (bq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL b_unexpected: actual=BVALID with empty queue required=no response");
          end else begin
            b_cur = bq.pop_front();
            b_have = 1'b1;
            check("rw_regs", 256'(rw_regs), 256'(b_cur.regs));
          end
        end
        check("wr_pulse", 256'(rw_wr_pulse), (rising && b_have) ? 256'(b_cur.pulse) : 256'(0));
        if (bvalid && bready && b_have) begin
          check("bresp", 256'(bresp), 256'(b_cur.resp));
          b_have = 1'b0;
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL r_unexpected: actual=RVALID with empty queue required=no response");
          end else begin
            r_exp_t re;
            re = rq.pop_front();
            check("rdata", 256'(rdata), 256'(re.data));
            check("rresp", 256'(rresp), 256'(re.resp));
          end
        end
        bvalid_prev = bvalid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 256'(awready), 256'(0));
    check({tag, "_wready"},  256'(wready),  256'(0));
    check({tag, "_arready"}, 256'(arready), 256'(0));
    check({tag, "_bvalid"},  256'(bvalid),  256'(0));
    check({tag, "_rvalid"},  256'(rvalid),  256'(0));
    check({tag, "_bresp"},   256'(bresp),   256'(0));
    check({tag, "_rresp"},   256'(rresp),   256'(0));
    check({tag, "_rdata"},   256'(rdata),   256'(0));
    check({tag, "_rw_regs"}, 256'(rw_regs), 256'(0));
    check({tag, "_pulse"},   256'(rw_wr_pulse), 256'(0));
  endtask

  initial begin
    bit ok;
    aresetn = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1; ro_regs = '0;
    for (int i = 0; i < NUM_RW; i++) mrw[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Full-word write, single-cycle BVALID, readback.
    axi_write(BASE + 32'h08, 32'hA5A5_1234, 4'hF);
    @(negedge clk);
    check("bvalid_hi", 256'(bvalid), 256'(1));
    check("rw2_value", 256'(rw_regs[64 +: 32]), 256'(32'hA5A5_1234));
    @(negedge clk);
    check("bvalid_lo", 256'(bvalid), 256'(0));
    axi_read(BASE + 32'h08);
    drain();

    // Partial strobes.
    axi_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    axi_write(BASE + 32'h14, 32'h1234_5678, 4'h5);
    axi_read(BASE + 32'h14);
    axi_write(BASE + 32'h18, 32'h9999_9999, 4'h0);
    axi_read(BASE + 32'h18);
    drain();

    // Read-only window and write rejection.
    ro_regs[31:0] = 32'hCAFE_0001;
    ro_regs[32*7 +: 32] = 32'h7777_0007;
    axi_read(BASE + 32'h20);
    axi_write(BASE + 32'h20, 32'h0BAD_0BAD, 4'hF);
    axi_read(BASE + 32'h20);
    axi_read(BASE + 32'h3C);
    drain();

    // Out of range and below base.
    axi_write(BASE + 32'h40, 32'h1357_9BDF, 4'hF);
    axi_read(BASE + 32'h40);
    axi_write(BASE - 32'h4, 32'h2468_ACE0, 4'hF);
    axi_read(BASE - 32'h4);
    drain();

    // Back-pressure on both response channels.
    bready = 1'b0; rready = 1'b0;
    axi_write(BASE + 32'h04, 32'h1111_2222, 4'hF);
    axi_read(BASE + 32'h04);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid && rvalid) begin ok = 1'b1; break; end
    end
    check("stall_valids", 256'(ok), 256'(1));
    @(posedge clk); #1;
    awaddr = BASE + 32'h08; wdata = 32'hEEEE_EEEE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = BASE; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid",  256'(bvalid),  256'(1));
      check("stall_bresp",   256'(bresp),   256'(0));
      check("stall_rvalid",  256'(rvalid),  256'(1));
      check("stall_rdata",   256'(rdata),   256'(32'h1111_2222));
      check("stall_awready", 256'(awready), 256'(0));
      check("stall_arready", 256'(arready), 256'(0));
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_bvalid", 256'(bvalid), 256'(0));
    check("release_rvalid", 256'(rvalid), 256'(0));
    drain();

    // Reset with a write response pending.
    axi_write(BASE + 32'h0C, 32'h0000_0055, 4'hF);
    drain();
    bready = 1'b0;
    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; break; end
    end
    check("pre_reset_bvalid", 256'(ok), 256'(1));
    @(posedge clk); #1;
    aresetn = 1'b0;
    bq.delete(); rq.delete();
    for (int i = 0; i < NUM_RW; i++) mrw[i] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid");
    @(posedge clk); #1;
    aresetn = 1'b1; bready = 1'b1;
    axi_read(BASE + 32'h0C);
    axi_write(BASE + 32'h0C, 32'h0BEE_F00D, 4'hF);
    axi_read(BASE + 32'h0C);
    drain();

    // Randomised traffic against the register-map model.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] addr;
      int kind;
      for (int k = 0; k < NUM_RO; k++) ro_regs[32*k +: 32] = $urandom;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       addr = BASE + 4 * $urandom_range(0, NUM_RW - 1);
        1:       addr = BASE + 4 * $urandom_range(NUM_RW, NUM_RW + NUM_RO - 1);
        2:       addr = BASE + 4 * $urandom_range(NUM_RW + NUM_RO, 64);
        default: addr = BASE - 4 * $urandom_range(1, 16);
      endcase
      addr[1:0] = 2'($urandom);
      if ($urandom_range(0, 1) == 0) axi_write(addr, $urandom, 4'($urandom));
      else axi_read(addr);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
